// File: rtl/esp32_i2s_rx.sv
// rtl/esp32_i2s_rx.sv - oversampled Philips I2S receiver presenting atomic L/R sample pairs
// BCLK/LRCLK/DIN are synchronised into clk; every slot decision is taken on a detected BCLK rise.
module esp32_i2s_rx #(
    parameter int SAMPLE_BITS = 16,
    parameter int IDLE_TO_CYC = 5_400_000,
    parameter int ERR_W       = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i2s_bclk,
    input  logic                          i2s_lrclk,
    input  logic                          i2s_din,
    output logic signed [SAMPLE_BITS-1:0] sample_l,
    output logic signed [SAMPLE_BITS-1:0] sample_r,
    output logic                          sample_valid,
    output logic [ERR_W-1:0]              frame_err_count,
    output logic                          active
);

    localparam int                 IDLE_W   = $clog2(IDLE_TO_CYC + 1);
    localparam logic [IDLE_W-1:0]  IDLE_MAX = IDLE_W'(IDLE_TO_CYC - 1);
    localparam logic [5:0]         SB       = 6'(SAMPLE_BITS);

    typedef enum logic [1:0] {ST_SYNC, ST_LEFT, ST_RIGHT} state_t;

    state_t                   state_q, state_d;
    logic [1:0]               bclk_s, lr_s, din_s;
    logic                     bclk_d, rise_q, ws_q, din_q, ws_prev;
    logic [5:0]               bitcnt, cnt_inc;
    logic [SAMPLE_BITS-1:0]   shift_q, shift_in, left_hold;
    logic                     left_ok;
    logic [IDLE_W-1:0]        idle_cnt;
    logic                     timeout, transition, slot_good;
    logic                     close_left, close_right, close_short;

    assign timeout    = !rise_q && (idle_cnt == IDLE_MAX);
    assign transition = ws_q != ws_prev;

    always_comb begin
        state_d     = state_q;
        close_left  = 1'b0;
        close_right = 1'b0;
        close_short = 1'b0;
        cnt_inc     = (bitcnt == 6'd63) ? bitcnt : bitcnt + 6'd1;
        shift_in    = (bitcnt < SB) ? {shift_q[SAMPLE_BITS-2:0], din_q} : shift_q;
        // The transition rise still carries the old slot's LSB, so it counts toward the close.
        slot_good   = cnt_inc >= SB;
        if (timeout) begin
            state_d = ST_SYNC;
        end else if (rise_q && transition) begin
            case (state_q)
                ST_SYNC: begin
                    if (!ws_q) state_d = ST_LEFT;
                end
                ST_LEFT: begin
                    state_d     = ST_RIGHT;
                    close_left  = slot_good;
                    close_short = !slot_good;
                end
                ST_RIGHT: begin
                    state_d     = ST_LEFT;
                    close_right = slot_good;
                    close_short = !slot_good;
                end
                default: state_d = ST_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bclk_s          <= '0;
            lr_s            <= '0;
            din_s           <= '0;
            bclk_d          <= 1'b0;
            rise_q          <= 1'b0;
            ws_q            <= 1'b0;
            din_q           <= 1'b0;
            ws_prev         <= 1'b0;
            state_q         <= ST_SYNC;
            bitcnt          <= '0;
            shift_q         <= '0;
            left_hold       <= '0;
            left_ok         <= 1'b0;
            idle_cnt        <= '0;
            sample_l        <= '0;
            sample_r        <= '0;
            sample_valid    <= 1'b0;
            frame_err_count <= '0;
            active          <= 1'b0;
        end else begin
            bclk_s       <= {bclk_s[0], i2s_bclk};
            lr_s         <= {lr_s[0], i2s_lrclk};
            din_s        <= {din_s[0], i2s_din};
            bclk_d       <= bclk_s[1];
            rise_q       <= bclk_s[1] & ~bclk_d;
            ws_q         <= lr_s[1];
            din_q        <= din_s[1];
            state_q      <= state_d;
            sample_valid <= 1'b0;

            if (rise_q)                   idle_cnt <= '0;
            else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + IDLE_W'(1);

            if (timeout) begin
                left_ok <= 1'b0;
                active  <= 1'b0;
                bitcnt  <= '0;
                shift_q <= '0;
            end else if (rise_q) begin
                ws_prev <= ws_q;
                if (transition) begin
                    bitcnt  <= '0;
                    shift_q <= '0;
                end else begin
                    bitcnt  <= cnt_inc;
                    shift_q <= shift_in;
                end
                if (close_short) begin
                    if (frame_err_count != '1) frame_err_count <= frame_err_count + ERR_W'(1);
                    if (state_q == ST_LEFT) left_ok <= 1'b0;
                end
                if (close_left) begin
                    left_hold <= shift_in;
                    left_ok   <= 1'b1;
                end
                if (close_right && left_ok) begin
                    sample_l     <= left_hold;
                    sample_r     <= shift_in;
                    sample_valid <= 1'b1;
                    active       <= 1'b1;
                    left_ok      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_esp32_i2s_rx.sv
// tb/tb_esp32_i2s_rx.sv - randomized I2S stream against a slot-level reference model
module tb_esp32_i2s_rx;

    localparam int HALF = 9;

    logic        clk = 1'b0, rst = 1'b1;
    logic        i2s_bclk = 1'b0, i2s_lrclk = 1'b0, i2s_din = 1'b0;
    logic [15:0] sample_l, sample_r;
    logic        sample_valid, active;
    logic [7:0]  frame_err_count;

    esp32_i2s_rx #(.SAMPLE_BITS(16), .IDLE_TO_CYC(100), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_din(i2s_din),
        .sample_l(sample_l), .sample_r(sample_r), .sample_valid(sample_valid),
        .frame_err_count(frame_err_count), .active(active)
    );

    always #9 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic [15:0] got_l[$], got_r[$];
    int          glitches = 0, pulse_cyc = 0;
    logic [15:0] pl = '0, pr = '0;
    logic        pv = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            pl = '0; pr = '0; pv = 1'b0;
        end else begin
            if (sample_valid) begin
                got_l.push_back(sample_l);
                got_r.push_back(sample_r);
                pulse_cyc = cyc;
                if (pv) glitches = glitches + 1;
            end else if (sample_l !== pl || sample_r !== pr) begin
                glitches = glitches + 1;
            end
            pl = sample_l; pr = sample_r; pv = sample_valid;
        end
    end

    // Slot-level reference: a slot is judged only by its width and the slot before it.
    bit          m_synced, m_lok, m_active;
    int          m_err, m_w;
    logic        m_cws;
    logic [31:0] m_data;
    logic [15:0] m_lhold, m_last_l, m_last_r;
    logic [15:0] exp_l[$], exp_r[$];
    logic        pend;
    int          last_rise_cyc, slot_rise_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks = checks + 1;
        assert (obs === expv) else begin
            errors = errors + 1;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_synced = 0; m_lok = 0; m_active = 0; m_err = 0;
        exp_l.delete(); exp_r.delete(); got_l.delete(); got_r.delete();
    endtask

    task automatic model_close(input logic new_ws);
        if (!m_synced) begin
            if (new_ws == 1'b0) m_synced = 1;
        end else if (m_w < 16) begin
            if (m_err < 255) m_err = m_err + 1;
            if (m_cws == 1'b0) m_lok = 0;
        end else if (m_cws == 1'b0) begin
            m_lok   = 1;
            m_lhold = 16'(m_data >> (m_w - 16));
        end else if (m_lok) begin
            m_last_l = m_lhold;
            m_last_r = 16'(m_data >> (m_w - 16));
            exp_l.push_back(m_last_l);
            exp_r.push_back(m_last_r);
            m_lok    = 0;
            m_active = 1;
        end
    endtask

    task automatic drive_bit(input logic ws, input logic d);
        i2s_bclk = 1'b0; i2s_lrclk = ws; i2s_din = d;
        repeat (HALF) @(negedge clk);
        i2s_bclk = 1'b1; last_rise_cyc = cyc;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_slot(input logic ws, input logic [31:0] data, input int w);
        model_close(ws);
        m_cws = ws; m_w = w; m_data = data;
        drive_bit(ws, pend);
        slot_rise_cyc = last_rise_cyc;
        for (int i = w - 1; i >= 1; i--) drive_bit(ws, data[i]);
        pend = data[0];
    endtask

    task automatic send_partial(input logic ws, input int n);
        if (ws != i2s_lrclk) begin
            model_close(ws);
            m_cws = ws; m_w = n;
        end
        drive_bit(ws, pend);
        for (int i = 1; i < n; i++) drive_bit(ws, 1'($urandom));
        pend = 1'($urandom);
    endtask

    task automatic checkpoint(input string tag);
        chk({tag, "_pulses"}, got_l.size(), exp_l.size());
        for (int i = 0; i < exp_l.size() && i < got_l.size(); i++) begin
            chk({tag, "_l"}, got_l[i], exp_l[i]);
            chk({tag, "_r"}, got_r[i], exp_r[i]);
        end
        exp_l.delete(); exp_r.delete(); got_l.delete(); got_r.delete();
        chk({tag, "_err"}, frame_err_count, m_err);
        chk({tag, "_active"}, active, m_active);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_sl"}, sample_l, 0);
        chk({tag, "_sr"}, sample_r, 0);
        chk({tag, "_valid"}, sample_valid, 0);
        chk({tag, "_err"}, frame_err_count, 0);
        chk({tag, "_active"}, active, 0);
    endtask

    initial begin
        pend = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Nominal 32-bit frames; first pair is directed, the rest random.
        send_slot(1'b1, $urandom, 32);
        send_slot(1'b0, {16'hCAFE, 16'($urandom)}, 32);
        send_slot(1'b1, {16'hBABE, 16'($urandom)}, 32);
        send_slot(1'b0, $urandom, 32);
        chk("latency", pulse_cyc - slot_rise_cyc, 4);
        chk("first_l", sample_l, 16'hCAFE);
        chk("first_r", sample_r, 16'hBABE);
        for (int f = 0; f < 4; f++) begin
            send_slot(1'b1, $urandom, 32);
            send_slot(1'b0, $urandom, 32);
        end
        checkpoint("frames");

        // A 10-bit left slot kills exactly one frame.
        send_slot(1'b1, $urandom, 32);
        send_slot(1'b0, $urandom, 10);
        send_slot(1'b1, $urandom, 32);
        send_slot(1'b0, $urandom, 32);
        chk("short_err", frame_err_count, 1);
        checkpoint("short");
        send_slot(1'b1, $urandom, 32);
        send_slot(1'b0, $urandom, 32);
        checkpoint("after_short");

        // Reset in the middle of a right slot.
        send_partial(1'b1, 12);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("mid_reset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        send_partial(1'b1, 8);
        send_slot(1'b0, $urandom, 32);
        send_slot(1'b1, $urandom, 32);
        checkpoint("resync_none");
        send_slot(1'b0, $urandom, 32);
        checkpoint("resync");

        // BCLK stops mid right slot, then resumes mid right slot.
        send_slot(1'b1, $urandom, 32);
        send_slot(1'b0, $urandom, 32);
        send_partial(1'b1, 12);
        checkpoint("pre_idle");
        repeat (70) @(negedge clk);
        chk("idle_still_active", active, 1);
        repeat (40) @(negedge clk);
        chk("idle_active", active, 0);
        chk("idle_hold_l", sample_l, m_last_l);
        chk("idle_hold_r", sample_r, m_last_r);
        m_synced = 0; m_lok = 0; m_active = 0;
        send_partial(1'b1, 10);
        send_slot(1'b0, $urandom, 32);
        send_slot(1'b1, $urandom, 32);
        checkpoint("restart_none");
        send_slot(1'b0, $urandom, 32);
        checkpoint("restart");

        // Exact-fit 16-bit slots at the signed extremes.
        send_slot(1'b1, $urandom, 32);
        send_slot(1'b0, 32'h0000_8000, 16);
        send_slot(1'b1, 32'h0000_7FFF, 16);
        send_slot(1'b0, $urandom, 16);
        checkpoint("fit16");
        chk("fit16_l", sample_l, 16'h8000);
        chk("fit16_l_signed", 32'($signed(sample_l)), 32'hFFFF_8000);
        chk("fit16_r_signed", 32'($signed(sample_r)), 32'h0000_7FFF);

        // 300 short slots after the open good left slot closes.
        for (int i = 0; i < 301; i++) send_slot((i % 2) == 0, $urandom, 4);
        checkpoint("saturate");
        chk("saturate_err", frame_err_count, 8'hFF);

        chk("atomic_updates", glitches, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
